// File: rtl/conv1_rm_pkg.sv
// Shared constants and state type for the conv1 row-major feature-map SRAM controller.
package conv1_rm_pkg;

    localparam int CONV1_RM_DATA_W = 16;
    localparam int CONV1_RM_ADDR_W = 9;
    localparam int CONV1_RM_DEPTH  = 336;

    typedef enum logic [1:0] {
        FILL,
        FULL,
        DRAIN
    } ctrl_state_e;

endpackage

// File: rtl/conv1_rm_sram_ctrl_if.sv
// Upstream write stream, downstream read stream and SRAM port-0 pins of the conv1 feature-map controller.
interface conv1_rm_sram_ctrl_if
    import conv1_rm_pkg::*;
#(
    parameter int DATA_WIDTH = CONV1_RM_DATA_W,
    parameter int ADDR_WIDTH = CONV1_RM_ADDR_W
) ();

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_start;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  full;
    logic                  sram_csb0;
    logic                  sram_web0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic [DATA_WIDTH-1:0] sram_dout0;

    // The controller is the slave of both streams and drives the macro pins.
    modport slave (
        input  wr_valid, wr_data, rd_start, rd_ready, sram_dout0,
        output wr_ready, rd_valid, rd_data, rd_last, full,
               sram_csb0, sram_web0, sram_addr0, sram_din0
    );

    modport master (
        output wr_valid, wr_data, rd_start, rd_ready, sram_dout0,
        input  wr_ready, rd_valid, rd_data, rd_last, full,
               sram_csb0, sram_web0, sram_addr0, sram_din0
    );

endinterface

// File: rtl/conv1_rm_rd_skid.sv
// Two-entry FIFO of {rd_last, data} that absorbs SRAM read data while the downstream stalls.
module conv1_rm_rd_skid #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                clk0,
    input  logic                rst_n,
    input  logic                push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                push_last,
    input  logic                pop,
    output logic [1:0]          count,
    output logic [DATA_WIDTH:0] head
);

    logic [DATA_WIDTH:0] mem_q [2];
    logic                rd_idx_q;
    logic                wr_idx_q;
    logic [1:0]          count_q;

    // NOTE: the two entries are reset as well so rd_data/rd_last are defined straight out of reset.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_idx_q <= 1'b0;
            wr_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_idx_q] <= {push_last, push_data};
                wr_idx_q        <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_idx_q];

endmodule

// File: rtl/conv1_rm_sram_ctrl.sv
// Port-0 master for the conv1 feature-map SRAM: sequential fill from a stream, ordered drain on command.
module conv1_rm_sram_ctrl
    import conv1_rm_pkg::*;
#(
    parameter int DATA_WIDTH = CONV1_RM_DATA_W,
    parameter int ADDR_WIDTH = CONV1_RM_ADDR_W,
    parameter int DEPTH      = CONV1_RM_DEPTH
) (
    input logic                 clk0,
    input logic                 rst_n,
    conv1_rm_sram_ctrl_if.slave bus
);

    // One extra bit so rd_ptr can sit at DEPTH once every address has been issued.
    localparam int               PTR_W  = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    ctrl_state_e           state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  do_write;
    logic                  do_read;
    logic                  pop;
    logic [2:0]            occ_after;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH:0]   skid_head;

    assign pop       = bus.rd_valid && bus.rd_ready;
    assign occ_after = 3'(skid_count) + 3'(inflight_q) - 3'(pop);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        do_write       = 1'b0;
        do_read        = 1'b0;
        bus.wr_ready   = (state_q == FILL);
        bus.full       = (state_q == FULL);
        bus.sram_csb0  = 1'b1;
        bus.sram_web0  = 1'b1;
        bus.sram_addr0 = addr_q;
        bus.sram_din0  = din_q;

        unique case (state_q)
            FILL: begin
                if (bus.wr_valid) begin
                    do_write       = 1'b1;
                    bus.sram_csb0  = 1'b0;
                    bus.sram_web0  = 1'b0;
                    bus.sram_addr0 = wr_ptr_q[ADDR_WIDTH-1:0];
                    bus.sram_din0  = bus.wr_data;
                    if (wr_ptr_q == LAST_P) begin
                        wr_ptr_d = '0;
                        state_d  = FULL;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (bus.rd_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Never let issued-but-unpopped words exceed the two skid slots.
                if (rd_ptr_q < DEPTH_P && occ_after < 3'd2) begin
                    do_read        = 1'b1;
                    bus.sram_csb0  = 1'b0;
                    bus.sram_addr0 = rd_ptr_q[ADDR_WIDTH-1:0];
                    rd_ptr_d       = rd_ptr_q + 1'b1;
                end
                if (pop && skid_count == 2'd1 && !inflight_q && rd_ptr_q == DEPTH_P) begin
                    state_d  = FILL;
                    rd_ptr_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= FILL;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            addr_q          <= '0;
            din_q           <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= do_read;
            inflight_last_q <= do_read && (rd_ptr_q == LAST_P);
            if (do_write || do_read) begin
                addr_q <= bus.sram_addr0;
            end
            if (do_write) begin
                din_q <= bus.wr_data;
            end
        end
    end

    // The macro's read data is only valid up to the edge after the read, so it is pushed there unconditionally.
    conv1_rm_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bus.sram_dout0),
        .push_last (inflight_last_q),
        .pop       (pop),
        .count     (skid_count),
        .head      (skid_head)
    );

    assign bus.rd_valid = (skid_count != 2'd0);
    assign bus.rd_data  = skid_head[DATA_WIDTH-1:0];
    assign bus.rd_last  = skid_head[DATA_WIDTH];

endmodule

// File: tb/tb_conv1_rm_sram_ctrl.sv
// Randomized bench for conv1_rm_sram_ctrl: a stream-level model checks the 336-word instance every cycle; a DEPTH=2 instance is pinned by hand.
module tb_conv1_rm_sram_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 336;

    localparam int P_FILL  = 0;
    localparam int P_FULL  = 1;
    localparam int P_DRAIN = 2;

    logic clk0 = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk0 = ~clk0;

    conv1_rm_sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus  ();
    conv1_rm_sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    conv1_rm_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk0  (clk0),
        .rst_n (rst_n),
        .bus   (bus)
    );

    conv1_rm_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(2)) dut2 (
        .clk0  (clk0),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Macro models: read data valid for one cycle after the read edge, garbage otherwise.
    logic [DW-1:0] sram_mem  [512];
    logic [DW-1:0] sram2_mem [512];

    always @(posedge clk0) begin
        logic          rd;
        logic [AW-1:0] a;
        rd = !bus.sram_csb0 && bus.sram_web0;
        a  = bus.sram_addr0;
        if (!bus.sram_csb0 && !bus.sram_web0) sram_mem[bus.sram_addr0] = bus.sram_din0;
        #1;
        bus.sram_dout0 = rd ? sram_mem[a] : 16'hDEAD;
    end

    always @(posedge clk0) begin
        logic          rd;
        logic [AW-1:0] a;
        rd = !bus2.sram_csb0 && bus2.sram_web0;
        a  = bus2.sram_addr0;
        if (!bus2.sram_csb0 && !bus2.sram_web0) sram2_mem[bus2.sram_addr0] = bus2.sram_din0;
        #1;
        bus2.sram_dout0 = rd ? sram2_mem[a] : 16'hBEEF;
    end

    // Stream-level model of the main instance.
    int            phase = P_FILL;
    int            writes = 0;
    int            reads = 0;
    int            popped = 0;
    int            drain_k = 0;
    int            drain_len = 0;
    logic [DW-1:0] mem_exp [DEPTH];
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_din = '0;
    logic [DW-1:0] first_word = '0;
    logic [DW-1:0] last_word = '0;

    always @(negedge clk0) begin
        if (!rst_n) begin
            phase     = P_FILL;
            writes    = 0;
            reads     = 0;
            popped    = 0;
            drain_k   = 0;
            last_addr = '0;
            last_din  = '0;
            check_bit("rst_wr_ready", bus.wr_ready, 1'b1);
            check_bit("rst_rd_valid", bus.rd_valid, 1'b0);
            check_bit("rst_rd_last", bus.rd_last, 1'b0);
            check_bit("rst_full", bus.full, 1'b0);
            check_bit("rst_csb", bus.sram_csb0, 1'b1);
            check_bit("rst_web", bus.sram_web0, 1'b1);
            check("rst_addr", 32'(bus.sram_addr0), 32'd0);
            check("rst_din", 32'(bus.sram_din0), 32'd0);
        end else begin
            check_bit("wr_ready", bus.wr_ready, phase == P_FILL);
            check_bit("full", bus.full, phase == P_FULL);
            case (phase)
                P_FILL: begin
                    check_bit("rd_valid_in_fill", bus.rd_valid, 1'b0);
                    check_bit("fill_csb", bus.sram_csb0, !bus.wr_valid);
                    if (bus.wr_valid) begin
                        check_bit("wr_web", bus.sram_web0, 1'b0);
                        check("wr_addr", 32'(bus.sram_addr0), writes);
                        check("wr_din", 32'(bus.sram_din0), 32'(bus.wr_data));
                        mem_exp[writes] = bus.wr_data;
                        last_addr       = AW'(writes);
                        last_din        = bus.wr_data;
                        writes++;
                        if (writes == DEPTH) phase = P_FULL;
                    end
                end
                P_FULL: begin
                    check_bit("rd_valid_in_full", bus.rd_valid, 1'b0);
                    check_bit("full_csb", bus.sram_csb0, 1'b1);
                    if (bus.rd_start) begin
                        phase   = P_DRAIN;
                        reads   = 0;
                        popped  = 0;
                        drain_k = 0;
                    end
                end
                default: begin
                    if (drain_k < 2) check_bit("first_valid_early", bus.rd_valid, 1'b0);
                    if (drain_k == 2) begin
                        check_bit("first_valid_latency", bus.rd_valid, 1'b1);
                        first_word = bus.rd_data;
                    end
                    if (bus.rd_valid) check_bit("valid_has_data", reads > popped, 1'b1);
                    if (!bus.sram_csb0) begin
                        check_bit("rd_web", bus.sram_web0, 1'b1);
                        check("rd_addr", 32'(bus.sram_addr0), reads);
                        last_addr = AW'(reads);
                        reads++;
                    end
                    if (bus.rd_valid && bus.rd_ready) begin
                        check("rd_data", 32'(bus.rd_data), 32'(mem_exp[popped]));
                        check_bit("rd_last", bus.rd_last, popped == DEPTH - 1);
                        if (popped == DEPTH - 1) last_word = bus.rd_data;
                        popped++;
                    end
                    check_bit("outstanding_le_2", (reads - popped) <= 2, 1'b1);
                    drain_k++;
                    if (popped == DEPTH) begin
                        phase     = P_FILL;
                        writes    = 0;
                        drain_len = drain_k;
                    end
                end
            endcase
            if (bus.sram_csb0) begin
                check("hold_addr", 32'(bus.sram_addr0), 32'(last_addr));
                check("hold_din", 32'(bus.sram_din0), 32'(last_din));
            end
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic do_fill(input bit rnd, input bit poke_start);
        int budget;
        bit poked;
        budget = 0;
        poked  = 1'b0;
        while (phase != P_FULL && budget < 4000) begin
            bus.wr_valid = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            bus.wr_data  = rnd ? 16'($urandom) : (16'(writes) ^ 16'hA5A5);
            bus.rd_start = 1'b0;
            if (poke_start && !poked && writes == 100) begin
                bus.rd_start = 1'b1;
                poked        = 1'b1;
            end
            tick();
            budget++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_start = 1'b0;
        check_bit("fill_completes", phase == P_FULL, 1'b1);
        if (!rnd) check("fill_cycles", budget, DEPTH);
        if (poke_start) check_bit("fill_start_poked", poked, 1'b1);
    endtask

    task automatic do_drain(input bit always_ready, input int reset_at);
        int budget;
        budget       = 0;
        bus.rd_start = 1'b1;
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        while (phase == P_DRAIN && budget < 5000) begin
            if (reset_at >= 0 && popped == reset_at) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n        = 1'b1;
                bus.rd_ready = 1'b0;
                tick();
                return;
            end
            bus.rd_ready = always_ready ? 1'b1 : ($urandom_range(0, 9) < 3);
            tick();
            budget++;
        end
        bus.rd_ready = 1'b0;
        check_bit("drain_completes", phase == P_FILL, 1'b1);
        check("drain_words", popped, DEPTH);
        if (always_ready) check("drain_cycles", drain_len, DEPTH + 2);
    endtask

    task automatic depth2_test();
        int reads2;
        reads2        = 0;
        bus2.wr_valid = 1'b1;
        bus2.wr_data  = 16'h1111;
        @(negedge clk0);
        check_bit("d2_wr0_csb", bus2.sram_csb0, 1'b0);
        check("d2_wr0_addr", 32'(bus2.sram_addr0), 32'd0);
        tick();
        bus2.wr_data = 16'h2222;
        @(negedge clk0);
        check("d2_wr1_addr", 32'(bus2.sram_addr0), 32'd1);
        tick();
        bus2.wr_valid = 1'b0;
        @(negedge clk0);
        check_bit("d2_full", bus2.full, 1'b1);
        check_bit("d2_wr_ready_low", bus2.wr_ready, 1'b0);
        tick();
        bus2.rd_start = 1'b1;
        bus2.rd_ready = 1'b0;
        tick();
        bus2.rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk0);
            if (!bus2.sram_csb0) reads2++;
            tick();
        end
        check("d2_reads_while_stalled", reads2, 2);
        @(negedge clk0);
        check_bit("d2_valid_stalled", bus2.rd_valid, 1'b1);
        check("d2_word0_held", 32'(bus2.rd_data), 32'h1111);
        tick();
        bus2.rd_ready = 1'b1;
        @(negedge clk0);
        check("d2_word0", 32'(bus2.rd_data), 32'h1111);
        check_bit("d2_word0_last", bus2.rd_last, 1'b0);
        tick();
        @(negedge clk0);
        check_bit("d2_word1_valid", bus2.rd_valid, 1'b1);
        check("d2_word1", 32'(bus2.rd_data), 32'h2222);
        check_bit("d2_word1_last", bus2.rd_last, 1'b1);
        tick();
        bus2.rd_ready = 1'b0;
        @(negedge clk0);
        check_bit("d2_done_valid", bus2.rd_valid, 1'b0);
        check_bit("d2_done_full", bus2.full, 1'b0);
        check_bit("d2_done_wr_ready", bus2.wr_ready, 1'b1);
    endtask

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_start  = 1'b0;
        bus.rd_ready  = 1'b0;
        bus2.wr_valid = 1'b0;
        bus2.wr_data  = '0;
        bus2.rd_start = 1'b0;
        bus2.rd_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Deterministic fill and full-rate drain.
        do_fill(1'b0, 1'b0);
        check_bit("after_fill_full", bus.full, 1'b1);
        check_bit("after_fill_wr_ready", bus.wr_ready, 1'b0);
        do_drain(1'b1, -1);
        check("first_word_literal", 32'(first_word), 32'hA5A5);
        check("last_word_literal", 32'(last_word), 32'hA4EA);

        // Random fill with an ignored rd_start, then a drain under 30% rd_ready.
        do_fill(1'b1, 1'b1);
        do_drain(1'b0, -1);

        // Reset in the middle of a drain, then refill with new data and drain it.
        do_fill(1'b1, 1'b0);
        do_drain(1'b0, 150);
        check_bit("post_reset_fill", phase == P_FILL, 1'b1);
        check("post_reset_writes", writes, 0);
        do_fill(1'b1, 1'b0);
        do_drain(1'b1, -1);

        depth2_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule
